// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multi-cycle controller and the MIPS datapath.
// The controller is the master: it consumes IR fields and Zero and drives every enable and select.
interface multicycle_control_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       PCWre;
  logic       IRWre;
  logic       RegWre;
  logic       MemWre;
  logic       MemRd;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ExtSel;
  logic [1:0] RegDst;
  logic [1:0] WrDataSrc;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;

  modport master (
    input  opcode, funct, Zero,
    output PCWre, IRWre, RegWre, MemWre, MemRd, ALUSrcA, ALUSrcB, ExtSel,
           RegDst, WrDataSrc, PCSrc, ALUOp, state
  );

  modport slave (
    output opcode, funct, Zero,
    input  PCWre, IRWre, RegWre, MemWre, MemRd, ALUSrcA, ALUSrcB, ExtSel,
           RegDst, WrDataSrc, PCSrc, ALUOp, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS controller: IF/ID/EXE/MEM/WB/HALT sequencer that owns every
// architectural write enable. Only the state is registered; all outputs are combinational.
module multicycle_control_unit #(
  parameter logic [5:0] HALT_OP  = 6'b111111,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input logic                      CLK,
  input logic                      RST,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SLL = 3'b101
  } alu_op_e;

  typedef enum logic [4:0] {
    I_NOP, I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_SLL, I_JR,
    I_ADDI, I_ANDI, I_ORI, I_SLTI, I_LW, I_SW, I_BEQ, I_BNE,
    I_J, I_JAL, I_HALT
  } instr_e;

  // A link into r0 would be discarded by the register file anyway, so skip the write.
  localparam logic LinkWriteEn = (LINK_REG != 5'd0);

  state_e  state_q, state_d;
  instr_e  instr;
  alu_op_e alu_op_w;
  logic    src_a_w, src_b_w, ext_w;

  logic       pc_wre, ir_wre, reg_wre, mem_wre, mem_rd;
  logic       alu_src_a, alu_src_b, ext_sel;
  logic [1:0] reg_dst, wr_data_src, pc_src;
  alu_op_e    alu_op;

  always_comb begin
    instr = I_NOP;
    if (bus.opcode == HALT_OP) begin
      instr = I_HALT;
    end else begin
      case (bus.opcode)
        6'b000000: begin
          case (bus.funct)
            6'b100000: instr = I_ADD;
            6'b100010: instr = I_SUB;
            6'b100100: instr = I_AND;
            6'b100101: instr = I_OR;
            6'b101010: instr = I_SLT;
            6'b000000: instr = I_SLL;
            6'b001000: instr = I_JR;
            default:   instr = I_NOP;
          endcase
        end
        6'b001000: instr = I_ADDI;
        6'b001100: instr = I_ANDI;
        6'b001101: instr = I_ORI;
        6'b001010: instr = I_SLTI;
        6'b100011: instr = I_LW;
        6'b101011: instr = I_SW;
        6'b000100: instr = I_BEQ;
        6'b000101: instr = I_BNE;
        6'b000010: instr = I_J;
        6'b000011: instr = I_JAL;
        default:   instr = I_NOP;
      endcase
    end
  end

  // ALU steering for instructions that reach EXE; held through MEM/WB so the
  // unregistered ALU result stays valid for the address and write-back phases.
  always_comb begin
    alu_op_w = ALU_ADD;
    src_a_w  = 1'b0;
    src_b_w  = 1'b0;
    ext_w    = 1'b1;
    case (instr)
      I_SUB, I_BEQ, I_BNE: alu_op_w = ALU_SUB;
      I_AND:               alu_op_w = ALU_AND;
      I_OR:                alu_op_w = ALU_OR;
      I_SLT:               alu_op_w = ALU_SLT;
      I_SLL: begin
        alu_op_w = ALU_SLL;
        src_a_w  = 1'b1;
      end
      I_ADDI, I_LW, I_SW: src_b_w = 1'b1;
      I_ANDI: begin
        alu_op_w = ALU_AND;
        src_b_w  = 1'b1;
        ext_w    = 1'b0;
      end
      I_ORI: begin
        alu_op_w = ALU_OR;
        src_b_w  = 1'b1;
        ext_w    = 1'b0;
      end
      I_SLTI: begin
        alu_op_w = ALU_SLT;
        src_b_w  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (RST) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    pc_wre      = 1'b0;
    ir_wre      = 1'b0;
    reg_wre     = 1'b0;
    mem_wre     = 1'b0;
    mem_rd      = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    ext_sel     = 1'b0;
    reg_dst     = 2'b00;
    wr_data_src = 2'b00;
    pc_src      = 2'b00;
    alu_op      = ALU_ADD;

    if (state_q inside {S_EXE, S_MEM, S_WB}) begin
      alu_op    = alu_op_w;
      alu_src_a = src_a_w;
      alu_src_b = src_b_w;
      ext_sel   = ext_w;
    end

    case (state_q)
      S_IF: begin
        ir_wre  = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (instr)
          I_J: begin
            pc_wre  = 1'b1;
            pc_src  = 2'b11;
            state_d = S_IF;
          end
          I_JAL: begin
            pc_wre      = 1'b1;
            pc_src      = 2'b11;
            reg_wre     = LinkWriteEn;
            reg_dst     = 2'b10;
            wr_data_src = 2'b10;
            state_d     = S_IF;
          end
          I_JR: begin
            pc_wre  = 1'b1;
            pc_src  = 2'b10;
            state_d = S_IF;
          end
          I_NOP: begin
            pc_wre  = 1'b1;
            state_d = S_IF;
          end
          I_HALT:  state_d = S_HALT;
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (instr)
          I_BEQ, I_BNE: begin
            pc_wre  = 1'b1;
            // Branch is taken when Zero matches the sense of the compare.
            if ((instr == I_BEQ) == bus.Zero) pc_src = 2'b01;
            state_d = S_IF;
          end
          I_LW, I_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (instr == I_SW) begin
          mem_wre = 1'b1;
          pc_wre  = 1'b1;
          state_d = S_IF;
        end else begin
          mem_rd  = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
        if (instr inside {I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_SLL}) reg_dst = 2'b01;
        if (instr == I_LW) wr_data_src = 2'b01;
        state_d = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Reset masks every write strobe immediately, not just from the next edge.
  assign bus.PCWre     = pc_wre  & ~RST;
  assign bus.IRWre     = ir_wre  & ~RST;
  assign bus.RegWre    = reg_wre & ~RST;
  assign bus.MemWre    = mem_wre & ~RST;
  assign bus.MemRd     = mem_rd  & ~RST;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ExtSel    = ext_sel;
  assign bus.RegDst    = reg_dst;
  assign bus.WrDataSrc = wr_data_src;
  assign bus.PCSrc     = pc_src;
  assign bus.ALUOp     = alu_op;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction stream against a per-instruction timeline model of the controller.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if bus ();

  multicycle_control_unit dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef enum {K_NOP, K_RALU, K_JR, K_IALU, K_LW, K_SW, K_BR, K_J, K_JAL, K_HALT} kind_e;

  typedef struct {
    kind_e      kind;
    logic [2:0] alu;
    logic       srca;
    logic       srcb;
    logic       ext;
    logic       bne;
  } info_t;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre, irwre, regwre, memwre, memrd, srca, srcb, ext;
    logic [1:0] regdst, wrsrc, pcsrc;
    logic [2:0] aluop;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic info_t decode(input logic [5:0] op, input logic [5:0] fn);
    info_t i;
    i.kind = K_NOP; i.alu = 3'd0; i.srca = 1'b0; i.srcb = 1'b0; i.ext = 1'b1; i.bne = 1'b0;
    case (op)
      6'd0: case (fn)
        6'b100000: i.kind = K_RALU;
        6'b100010: begin i.kind = K_RALU; i.alu = 3'd1; end
        6'b100100: begin i.kind = K_RALU; i.alu = 3'd2; end
        6'b100101: begin i.kind = K_RALU; i.alu = 3'd3; end
        6'b101010: begin i.kind = K_RALU; i.alu = 3'd4; end
        6'b000000: begin i.kind = K_RALU; i.alu = 3'd5; i.srca = 1'b1; end
        6'b001000: i.kind = K_JR;
        default:   i.kind = K_NOP;
      endcase
      6'b001000: begin i.kind = K_IALU; i.srcb = 1'b1; end
      6'b001100: begin i.kind = K_IALU; i.alu = 3'd2; i.srcb = 1'b1; i.ext = 1'b0; end
      6'b001101: begin i.kind = K_IALU; i.alu = 3'd3; i.srcb = 1'b1; i.ext = 1'b0; end
      6'b001010: begin i.kind = K_IALU; i.alu = 3'd4; i.srcb = 1'b1; end
      6'b100011: begin i.kind = K_LW; i.srcb = 1'b1; end
      6'b101011: begin i.kind = K_SW; i.srcb = 1'b1; end
      6'b000100: begin i.kind = K_BR; i.alu = 3'd1; end
      6'b000101: begin i.kind = K_BR; i.alu = 3'd1; i.bne = 1'b1; end
      6'b000010: i.kind = K_J;
      6'b000011: i.kind = K_JAL;
      6'b111111: i.kind = K_HALT;
      default:   i.kind = K_NOP;
    endcase
    return i;
  endfunction

  task automatic check_outputs(input exp_t e, input string tag);
    check({tag, ".state"},     32'(bus.state),     32'(e.st));
    check({tag, ".PCWre"},     32'(bus.PCWre),     32'(e.pcwre));
    check({tag, ".IRWre"},     32'(bus.IRWre),     32'(e.irwre));
    check({tag, ".RegWre"},    32'(bus.RegWre),    32'(e.regwre));
    check({tag, ".MemWre"},    32'(bus.MemWre),    32'(e.memwre));
    check({tag, ".MemRd"},     32'(bus.MemRd),     32'(e.memrd));
    check({tag, ".ALUSrcA"},   32'(bus.ALUSrcA),   32'(e.srca));
    check({tag, ".ALUSrcB"},   32'(bus.ALUSrcB),   32'(e.srcb));
    check({tag, ".ExtSel"},    32'(bus.ExtSel),    32'(e.ext));
    check({tag, ".RegDst"},    32'(bus.RegDst),    32'(e.regdst));
    check({tag, ".WrDataSrc"}, 32'(bus.WrDataSrc), 32'(e.wrsrc));
    check({tag, ".PCSrc"},     32'(bus.PCSrc),     32'(e.pcsrc));
    check({tag, ".ALUOp"},     32'(bus.ALUOp),     32'(e.aluop));
  endtask

  task automatic check_enables_off(input string tag);
    check({tag, ".PCWre"},  32'(bus.PCWre),  32'd0);
    check({tag, ".IRWre"},  32'(bus.IRWre),  32'd0);
    check({tag, ".RegWre"}, 32'(bus.RegWre), 32'd0);
    check({tag, ".MemWre"}, 32'(bus.MemWre), 32'd0);
    check({tag, ".MemRd"},  32'(bus.MemRd),  32'd0);
  endtask

  // Entered and left just after a falling edge; RST is held for the given number of rising edges.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    check_enables_off("reset_entry");
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #1;
      check("reset.state", 32'(bus.state), 32'd0);
      check_enables_off("reset_hold");
    end
    rst = 1'b0;
  endtask

  // zmode < 0 randomizes Zero each cycle; max_steps truncates the instruction to model an abort.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int max_steps, input string name);
    info_t inf;
    int    path[$];
    int    n;
    logic  zero;
    exp_t  e;
    inf = decode(op, fn);
    case (inf.kind)
      K_BR:           path = {0, 1, 2};
      K_RALU, K_IALU: path = {0, 1, 2, 4};
      K_SW:           path = {0, 1, 2, 3};
      K_LW:           path = {0, 1, 2, 3, 4};
      default:        path = {0, 1};
    endcase
    n = (max_steps < path.size()) ? max_steps : path.size();
    for (int k = 0; k < n; k++) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.opcode = op;
      bus.funct  = fn;
      bus.Zero   = zero;
      #1;
      e        = '0;
      e.st     = 3'(path[k]);
      e.irwre  = (path[k] == 0);
      e.pcwre  = (k == path.size() - 1) && (inf.kind != K_HALT);
      if (path[k] >= 2) begin
        e.aluop = inf.alu;
        e.srca  = inf.srca;
        e.srcb  = inf.srcb;
        e.ext   = inf.ext;
      end
      if (path[k] == 1 && (inf.kind == K_J || inf.kind == K_JAL)) e.pcsrc = 2'b11;
      if (path[k] == 1 && inf.kind == K_JR) e.pcsrc = 2'b10;
      if (path[k] == 1 && inf.kind == K_JAL) begin
        e.regwre = 1'b1;
        e.regdst = 2'b10;
        e.wrsrc  = 2'b10;
      end
      if (path[k] == 2 && inf.kind == K_BR && (inf.bne ? !zero : zero)) e.pcsrc = 2'b01;
      e.memrd  = (path[k] == 3) && (inf.kind == K_LW);
      e.memwre = (path[k] == 3) && (inf.kind == K_SW);
      if (path[k] == 4) begin
        e.regwre = 1'b1;
        e.regdst = (inf.kind == K_RALU) ? 2'b01 : 2'b00;
        e.wrsrc  = (inf.kind == K_LW) ? 2'b01 : 2'b00;
      end
      check_outputs(e, $sformatf("%s[%0d]", name, k));
      @(negedge clk);
    end
    if (inf.kind == K_HALT && n == path.size()) begin
      for (int c = 0; c < 12; c++) begin
        bus.opcode = 6'($urandom);
        bus.Zero   = 1'($urandom_range(0, 1));
        #1;
        check("halt.state", 32'(bus.state), 32'd5);
        check_enables_off("halt_hold");
        @(negedge clk);
      end
      do_reset(1);
    end
  endtask

  logic [5:0] op_tab [17] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                              6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b100011,
                              6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011};
  logic [5:0] fn_tab [17] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                              6'b000000, 6'b001000, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                              6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         sel;
    logic [5:0] op, fn;
    rst        = 1'b1;
    bus.opcode = 6'd0;
    bus.funct  = 6'd0;
    bus.Zero   = 1'b0;
    do_reset(2);

    run_instr(6'd0,      6'b100000, -1, 99, "add");
    run_instr(6'b100011, 6'd0,      -1, 99, "lw");
    run_instr(6'b101011, 6'd0,      -1, 99, "sw");
    run_instr(6'b000100, 6'd0,       1, 99, "beq_z1");
    run_instr(6'b000101, 6'd0,       1, 99, "bne_z1");
    run_instr(6'b000100, 6'd0,       0, 99, "beq_z0");
    run_instr(6'b000101, 6'd0,       0, 99, "bne_z0");
    run_instr(6'b000011, 6'd0,      -1, 99, "jal");
    run_instr(6'b110000, 6'd0,      -1, 99, "undef_op");
    run_instr(6'd0,      6'b111111, -1, 99, "undef_funct");
    run_instr(6'd0,      6'b000000, -1, 99, "sll");
    run_instr(6'b001101, 6'd0,      -1, 99, "ori");

    // Abort a store while it sits in MEM: the write strobe must drop with RST.
    run_instr(6'b101011, 6'd0, -1, 3, "sw_abort");
    rst = 1'b1;
    #1;
    check("sw_abort.state", 32'(bus.state), 32'd3);
    check_enables_off("sw_abort_now");
    @(negedge clk);
    #1;
    check("sw_abort.after", 32'(bus.state), 32'd0);
    check_enables_off("sw_abort_after");
    do_reset(1);

    run_instr(6'b111111, 6'd0, -1, 99, "halt");

    for (int it = 0; it < 300; it++) begin
      sel = int'($urandom_range(0, 21));
      if (sel < 17) begin
        op = op_tab[sel];
        fn = fn_tab[sel];
      end else if (sel == 17) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end else if (sel == 18) begin
        op = 6'd0;
        fn = 6'($urandom);
      end else begin
        op = op_tab[$urandom_range(0, 16)];
        fn = fn_tab[$urandom_range(0, 16)];
      end
      if (sel == 21) begin
        run_instr(op, fn, -1, int'($urandom_range(1, 4)), "rand_abort");
        do_reset(int'($urandom_range(1, 2)));
      end else if (sel == 20 && $urandom_range(0, 7) == 0) begin
        run_instr(6'b111111, 6'd0, -1, 99, "rand_halt");
      end else begin
        run_instr(op, fn, -1, 99, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
